uart_tx_8n1: RTL and testbench
==============================

Name: uart_tx_8n1

Overview:
- Serial UART transmitter for the lab boards: accepts a byte over a valid/ready handshake and drives the `uart_tx` pin of lab_top.
- Frame: 1 start bit, data LSB first, optional parity, 1 or 2 stop bits.
- Sits between lab logic (keys, switches, counters) and the board `uart_tx` pin, which idles high.
- Transmit side of the pair whose receive end consumes `uart_rx`.

Parameters:
- clk_mhz, 50, system clock frequency in MHz.
- baud_rate, 115200, line rate in bit/s.
- w_data, 8, data bits per frame (5..8).
- parity, 0, 0 = none, 1 = even, 2 = odd.
- stop_bits, 1, number of stop bits (1 or 2).

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst, input, 1, asynchronous active-low reset (0 = reset asserted).
- in_valid, input, 1, byte offered.
- in_ready, output, 1, transmitter can accept a byte this cycle.
- in_data, input, w_data, byte to send.
- uart_tx, output, 1, serial line (registered, idle high).
- busy, output, 1, frame in progress (state != IDLE).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous, active-low.
- Reset values: uart_tx = 1, busy = 0, state = IDLE, baud counter = 0, shift register = 0. in_ready = 1 once rst is released.
- Baud period: CLKS_PER_BIT = (clk_mhz*1_000_000 + baud_rate/2) / baud_rate, rounded to nearest. Elaboration error if the result is < 2.
- Counter width: $clog2(CLKS_PER_BIT).
- Each bit is held for exactly CLKS_PER_BIT cycles.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - in_ready = 1, uart_tx = 1.
  - On in_valid && in_ready: latch in_data into the shift register, compute the parity bit, go to START.
- START: uart_tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - uart_tx = shift[0]; shift right at the end of each bit period.
  - After bit w_data-1, go to PARITY if parity != 0, else STOP.
- PARITY:
  - uart_tx = parity bit for one bit period.
  - Even: XOR of the data bits. Odd: inverted XOR.
  - Then go to STOP.
- STOP: uart_tx = 1 for stop_bits * CLKS_PER_BIT cycles, then go to IDLE.
- Latency: uart_tx falls in the first cycle after the handshake edge.
- Frame length: (1 + w_data + (parity != 0) + stop_bits) * CLKS_PER_BIT cycles.
- Back-to-back: in_ready is combinational from (state == IDLE). A byte held valid continuously gives exactly 1 idle-high cycle between frames.
- in_valid while busy: ignored, since in_ready = 0; the byte is not latched. in_data may change freely after the handshake.
- Reset mid-frame: uart_tx returns high immediately (asynchronously); the frame is abandoned and not resumed.
- Counter wrap: the baud counter reloads to 0 at each bit boundary; no free-running drift across frames.

Decomposition:
- Package `uart_pkg`:
  - state enum uart_tx_state_t.
  - parity enum (NONE/EVEN/ODD).
  - constant function clks_per_bit(clk_mhz, baud_rate), shared with the receiver.
- Sub-module `uart_baud_tick`:
  - Counter with enable and synchronous restart.
  - Emits a one-cycle tick at the end of each bit period.
  - Same async active-low reset.

Test Plan:
- Use clk_mhz=1, baud_rate=250000 (CLKS_PER_BIT=4), 8N1. Send 0x55 → uart_tx = 0, then 1,0,1,0,1,0,1,0, then 1. Each bit lasts 4 cycles; frame is 40 cycles; busy is high for 40 cycles; the first low is 1 cycle after the handshake.
- parity=1 (even), send 0x07 → parity bit = 1. parity=2 (odd), send 0x07 → parity bit = 0. Frame is 44 cycles.
- in_valid held high with 0xA3 then 0x3C → two frames with exactly 1 idle-high cycle between them. in_ready pulses for exactly 1 cycle per frame.
- in_valid=1 with 0xFF during the DATA state of an 0x00 frame → the line still carries 0x00. 0xFF is not sent until in_valid is re-sampled in IDLE.
- Drive rst=0 during data bit 3 → uart_tx=1, busy=0, in_ready=0 while reset is asserted. After release, in_ready=1 and a new 0x81 frame is transmitted correctly.
- stop_bits=2, send 0x00 → the stop level stays high for 8 cycles before in_ready rises.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the lab UART pair: FSM state and parity encodings,
// plus the baud-period calculation used by both transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } uart_parity_t;

    // Clock cycles per bit, rounded to the nearest integer
    function automatic int clks_per_bit(input int clk_mhz, input int baud_rate);
        longint num;
        num = longint'(clk_mhz) * 64'd1_000_000 + longint'(baud_rate / 2);
        return int'(num / longint'(baud_rate));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts while enabled and emits a one-cycle tick on the
// last cycle of each bit period, then reloads to zero.
module uart_baud_tick #(
    parameter int period = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int w_cnt = (period > 1) ? $clog2(period) : 1;
    localparam logic [w_cnt-1:0] LAST = w_cnt'(period - 1);

    logic [w_cnt-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST)
                count <= '0;
            else
                count <= count + 1'b1;
        end
    end

    assign tick = enable && !restart && (count == LAST);

endmodule

// File: rtl/uart_tx_8n1.sv
// UART transmitter: byte in over valid/ready, serial frame out on uart_tx
// (start, data LSB first, optional parity, 1 or 2 stop bits).
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter int clk_mhz   = 50,
    parameter int baud_rate = 115200,
    parameter int w_data    = 8,
    parameter int parity    = 0,
    parameter int stop_bits = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [w_data-1:0] in_data,
    output logic              uart_tx,
    output logic              busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(clk_mhz, baud_rate);
    localparam uart_parity_t PAR_MODE = (parity == 1) ? EVEN :
                                        (parity == 2) ? ODD  : NONE;
    localparam logic [2:0] LAST_DATA = 3'(w_data - 1);
    localparam logic [2:0] LAST_STOP = 3'(stop_bits - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_8n1: clk_mhz/baud_rate gives fewer than 2 clocks per bit");
    end
    if (w_data < 5 || w_data > 8) begin : g_bad_width
        $error("uart_tx_8n1: w_data must be 5..8");
    end
    if (parity < 0 || parity > 2) begin : g_bad_parity
        $error("uart_tx_8n1: parity must be 0, 1 or 2");
    end
    if (stop_bits < 1 || stop_bits > 2) begin : g_bad_stop
        $error("uart_tx_8n1: stop_bits must be 1 or 2");
    end

    uart_tx_state_t    state;
    logic [w_data-1:0] shift;
    logic              parity_bit;
    logic [2:0]        bit_idx;
    logic              tick;
    logic              accept;

    // Reset gating keeps in_ready low while reset is held
    assign in_ready = rst && (state == IDLE);
    assign accept   = in_valid && in_ready;

    uart_baud_tick #(
        .period(CLKS_PER_BIT)
    ) baud (
        .clk    (clk),
        .rst    (rst),
        .enable (state != IDLE),
        .restart(accept),
        .tick   (tick)
    );

    // uart_tx is loaded with the next bit's level on the transition edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift      <= '0;
            parity_bit <= 1'b0;
            bit_idx    <= '0;
            uart_tx    <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                    if (accept) begin
                        shift      <= in_data;
                        parity_bit <= (PAR_MODE == ODD) ? ~^in_data : ^in_data;
                        bit_idx    <= '0;
                        uart_tx    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        uart_tx <= shift[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift <= shift >> 1;
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            if (PAR_MODE != NONE) begin
                                uart_tx <= parity_bit;
                                state   <= PARITY;
                            end else begin
                                uart_tx <= 1'b1;
                                state   <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            uart_tx <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        uart_tx <= 1'b1;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1: four instances (8N1, even, odd, two stop bits) at
// 4 clocks per bit, checked cycle by cycle against an expected-frame model.
module tb_uart_tx_8n1;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] uart_tx;
    logic [3:0] busy;
    logic [7:0] in_data [4];

    int check_count = 0;
    int fail_count  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_8n1 #(
            .clk_mhz  (1),
            .baud_rate(250000),
            .w_data   (8),
            .parity   ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
            .stop_bits((g == 3) ? 2 : 1)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .in_data (in_data[g]),
            .uart_tx (uart_tx[g]),
            .busy    (busy[g])
        );
    end

    function automatic int par_mode(input int ch);
        return (ch == 1) ? 1 : ((ch == 2) ? 2 : 0);
    endfunction

    function automatic int stop_count(input int ch);
        return (ch == 3) ? 2 : 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Offers a byte and returns #1 after the handshake edge
    task automatic applyStimulus(input int ch, input logic [7:0] b, input bit keep_valid);
        int n;
        n = 0;
        in_valid[ch] = 1'b1;
        in_data[ch]  = b;
        while (!in_ready[ch] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput($sformatf("ch%0d_handshake_wait", ch), 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        if (!keep_valid) begin
            in_valid[ch] = 1'b0;
            in_data[ch]  = 8'($urandom);
        end
    endtask

    // Expected line level is built from the frame rules, one entry per bit
    task automatic checkFrame(input int ch, input logic [7:0] b);
        logic bits[$];
        bits.push_back(1'b0);
        for (int j = 0; j < 8; j++) bits.push_back(b[j]);
        if (par_mode(ch) == 1) bits.push_back(^b);
        if (par_mode(ch) == 2) bits.push_back(~^b);
        for (int j = 0; j < stop_count(ch); j++) bits.push_back(1'b1);
        for (int i = 0; i < bits.size() * CPB; i++) begin
            checkOutput($sformatf("ch%0d_b%02h_tx_cyc%0d", ch, b, i), 32'(uart_tx[ch]), 32'(bits[i / CPB]));
            checkOutput($sformatf("ch%0d_busy_cyc%0d", ch, i), 32'(busy[ch]), 32'd1);
            checkOutput($sformatf("ch%0d_ready_cyc%0d", ch, i), 32'(in_ready[ch]), 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput($sformatf("ch%0d_idle_tx", ch), 32'(uart_tx[ch]), 32'd1);
        checkOutput($sformatf("ch%0d_idle_busy", ch), 32'(busy[ch]), 32'd0);
        checkOutput($sformatf("ch%0d_idle_ready", ch), 32'(in_ready[ch]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        fail_count++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int ch;
        rst      = 1'b1;
        in_valid = '0;
        for (int i = 0; i < 4; i++) in_data[i] = '0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("reset_tx", 32'(uart_tx), 32'hF);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_ready", 32'(in_ready), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("release_ready", 32'(in_ready), 32'hF);
        checkOutput("release_tx", 32'(uart_tx), 32'hF);

        $display("[TB] directed frames");
        applyStimulus(0, 8'h55, 1'b0);
        checkFrame(0, 8'h55);
        applyStimulus(1, 8'h07, 1'b0);
        checkFrame(1, 8'h07);
        applyStimulus(2, 8'h07, 1'b0);
        checkFrame(2, 8'h07);
        applyStimulus(3, 8'h00, 1'b0);
        checkFrame(3, 8'h00);

        $display("[TB] back-to-back frames");
        applyStimulus(0, 8'hA3, 1'b1);
        in_data[0] = 8'h3C;
        checkFrame(0, 8'hA3);
        applyStimulus(0, 8'h3C, 1'b0);
        checkFrame(0, 8'h3C);

        $display("[TB] valid while busy");
        applyStimulus(0, 8'h00, 1'b0);
        fork
            checkFrame(0, 8'h00);
            begin
                repeat (12) @(negedge clk);
                in_valid[0] = 1'b1;
                in_data[0]  = 8'hFF;
            end
        join
        applyStimulus(0, 8'hFF, 1'b0);
        checkFrame(0, 8'hFF);

        $display("[TB] reset mid-frame");
        b = 8'($urandom);
        applyStimulus(0, b, 1'b0);
        repeat (17) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_reset_bit3", 32'(uart_tx[0]), 32'(b[3]));
        rst = 1'b0;
        #1;
        checkOutput("midreset_tx", 32'(uart_tx[0]), 32'd1);
        checkOutput("midreset_busy", 32'(busy[0]), 32'd0);
        checkOutput("midreset_ready", 32'(in_ready[0]), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("held_reset_ready", 32'(in_ready[0]), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("post_reset_ready", 32'(in_ready[0]), 32'd1);
        checkOutput("post_reset_tx", 32'(uart_tx[0]), 32'd1);
        applyStimulus(0, 8'h81, 1'b0);
        checkFrame(0, 8'h81);

        $display("[TB] random frames");
        for (int k = 0; k < 24; k++) begin
            ch = $urandom_range(0, 3);
            b  = 8'($urandom);
            applyStimulus(ch, b, 1'b0);
            checkFrame(ch, b);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
